// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - multi-joint servo pulse-width ramp sequencer
module servo_motion_sequencer #(
  parameter int N_JOINTS    = 4,
  parameter int FRAME_TICKS = 500000,
  parameter int MIN_US      = 650,
  parameter int MAX_US      = 2600,
  parameter int HOME_US     = 1625,
  parameter int STEP_US     = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_joint,
  input  logic [15:0]             cmd_us,
  output logic                    cmd_err,
  output logic [32*N_JOINTS-1:0]  control,
  output logic                    frame_tick,
  output logic                    busy,
  output logic                    done
);

  localparam int              CW       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME_TICKS - 1);
  localparam logic [15:0]     STEP     = 16'(STEP_US);
  localparam logic [15:0]     LO       = 16'(MIN_US);
  localparam logic [15:0]     HI       = 16'(MAX_US);
  localparam logic [15:0]     HOME     = 16'(HOME_US);
  localparam logic [2:0]      IDX_LAST = 3'(N_JOINTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_CHECK} state_t;

  logic [CW-1:0] cnt_q;
  logic          frame_tick_q;
  state_t        state_q;
  logic [2:0]    idx_q;
  logic          pending_q;
  logic          cmd_ready_q;
  logic          cmd_err_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   live_q   [N_JOINTS];
  logic [15:0]   target_q [N_JOINTS];

  logic          accept;
  logic          joint_ok;
  logic [15:0]   cmd_clamped;
  logic          any_diff;

  // Move live toward target by at most STEP; compare first so unsigned math never wraps.
  function automatic logic [15:0] step_fn(input logic [15:0] live, input logic [15:0] tgt);
    logic [15:0] r;
    if (tgt >= live) begin
      r = ((tgt - live) <= STEP) ? tgt : live + STEP;
    end else begin
      r = ((live - tgt) <= STEP) ? tgt : live - STEP;
    end
    return r;
  endfunction

  assign accept   = cmd_valid & cmd_ready_q;
  assign joint_ok = (32'(cmd_joint) < 32'(N_JOINTS));

  // Clamp the requested width into the legal servo range.
  always_comb begin
    cmd_clamped = cmd_us;
    if (cmd_us < LO) begin
      cmd_clamped = LO;
    end else if (cmd_us > HI) begin
      cmd_clamped = HI;
    end
  end

  // Any joint still away from its target.
  always_comb begin
    any_diff = 1'b0;
    for (int j = 0; j < N_JOINTS; j++) begin
      if (live_q[j] != target_q[j]) any_diff = 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_JOINTS; g++) begin : g_lane
      assign control[32*g +: 32] = {16'd0, live_q[g]};
    end
  endgenerate

  // Free-running frame counter; frame_tick is the registered wrap indication.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= (cnt_q == CNT_LAST);
      cnt_q        <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Command intake plus the per-frame IDLE -> UPDATE (one joint per cycle) -> CHECK walk.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      pending_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int j = 0; j < N_JOINTS; j++) begin
        live_q[j]   <= HOME;
        target_q[j] <= HOME;
      end
    end else begin
      cmd_err_q <= 1'b0;
      done_q    <= 1'b0;

      // Commands only land while IDLE, so they never race the joint walk.
      if (accept) begin
        if (joint_ok) begin
          for (int j = 0; j < N_JOINTS; j++) begin
            if (cmd_joint == 3'(j)) begin
              target_q[j] <= cmd_clamped;
              if (cmd_clamped != live_q[j]) busy_q <= 1'b1;
            end
          end
        end else begin
          cmd_err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          // The tick cycle itself starts the walk, so a same-cycle command is still taken.
          if (pending_q || frame_tick_q) begin
            state_q     <= S_UPDATE;
            idx_q       <= 3'd0;
            pending_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_UPDATE: begin
          cmd_ready_q <= 1'b0;
          for (int j = 0; j < N_JOINTS; j++) begin
            if (idx_q == 3'(j)) live_q[j] <= step_fn(live_q[j], target_q[j]);
          end
          idx_q <= idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_q <= S_CHECK;
        end
        S_CHECK: begin
          busy_q      <= any_diff;
          done_q      <= busy_q & ~any_diff;
          state_q     <= S_IDLE;
          cmd_ready_q <= ~(pending_q | frame_tick_q);
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase

      // A tick arriving mid-walk is remembered rather than dropped.
      if (frame_tick_q && state_q != S_IDLE) pending_q <= 1'b1;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign cmd_err    = cmd_err_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
